int_reg_scoreboard: RTL and testbench
=====================================

# int_reg_scoreboard

Integer-register scoreboard for long-latency writers: loads, AMOs, MMIO loads and multi-cycle FP-to-int ops. It sits beside the ID stage. It records destination registers whose results are not yet available for bypass, and stalls ID on RAW/WAW hazards against them. Release happens when the writer reaches WB. It is the producer-side counterpart of operand forwarding: forwarding consumes results, this block tracks results still in flight.

## Interface
- NUM_REGS, 32, architectural integer registers (x0 never tracked)
- MAX_PENDING, 4, maximum simultaneously pending long writers
- CNT_W, 16, width of stall-cycle statistics counter
- i_clk  in  1  clock
- i_rst_n  in  1  reset; asynchronous, active-low
- i_flush  in  1  pipeline flush (branch mispredict/trap)
- i_hold  in  1  external pipeline stall; ID instruction not advancing
- i_id_valid  in  1  valid instruction in ID
- i_id_rs1 / i_id_rs2  in  5  source register indices
- i_id_rs1_used / i_id_rs2_used  in  1  source actually read
- i_id_rd  in  5  destination register
- i_id_long_write  in  1  instruction is a long-latency integer writer
- i_id_mem_op  in  1  long writer is memory-side (load/LR/AMO); survives flush
- i_wb_valid  in  1  long writer result written back this cycle
- i_wb_rd  in  5  register written by that writer
- o_stall  out  1  hold ID this cycle
- o_pending  out  $clog2(MAX_PENDING+1)  registered count of busy registers
- o_stall_cycles  out  CNT_W  stall statistics (see Configuration)

## Operation
- State: busy[NUM_REGS-1:1], mem[NUM_REGS-1:1], pending counter. All outputs and state reset to 0.
- Hazard (combinational from registered state): raw1 = rs1_used & rs1!=0 & busy[rs1]; raw2 likewise; waw = long_write & rd!=0 & busy[rd]; full = long_write & rd!=0 & pending==MAX_PENDING.
- o_stall = i_id_valid & (raw1 | raw2 | waw | full).
- Issue: i_id_valid & i_id_long_write & rd!=0 & ~o_stall & ~i_hold & ~i_flush → busy[rd]<=1, mem[rd]<=i_id_mem_op, pending+1.
- Completion: i_wb_valid & busy[wb_rd] → busy and mem cleared, pending−1. Completion to a non-busy register or to x0 is ignored.
- Flush: clears every busy[r] with mem[r]==0. Memory-side entries stay until their WB completion. pending is reduced by the number cleared.
- Simultaneous events: issue and completion on different registers → pending unchanged. Flush + issue → issue dropped. Flush + completion of a mem entry → entry cleared, counted once.
- Issue to an already-busy rd cannot occur (WAW stall). pending never exceeds MAX_PENDING and never underflows.

## Timing
- o_stall: zero-latency combinational. No same-cycle WB bypass: stall deasserts the cycle after i_wb_valid, when the forwarding path supplies WB data.
- busy/mem/pending update on the rising i_clk edge. o_pending is registered.
- Reset assertion mid-operation clears all state immediately (async). The first issue is accepted on the first edge after deassertion.

## Configuration
- FROST_SCOREBOARD_STATS_EN defined: o_stall_cycles increments each cycle with o_stall=1. It saturates at 2^CNT_W−1. Reset and i_flush do not clear it, except async reset clears it to 0.
- Undefined: o_stall_cycles tied to 0 and no counter flops are built.

## Test plan
- Load issues rd=5 (mem_op=1), next instruction reads rs1=5 → o_stall=1 until the cycle after i_wb_valid with wb_rd=5. Then o_stall=0 and o_pending returns 0.
- Long writer to rd=0 → no busy bit set, o_pending stays 0, and a later read of x0 never stalls.
- MAX_PENDING=4: issue rd=1..4, then a fifth long writer rd=6 → o_stall=1 (full). WB of rd=2 → fifth issues the following cycle, and o_pending=4.
- Busy rd=7 (mem_op=0) and rd=8 (mem_op=1), assert i_flush → busy[7]=0, busy[8]=1, o_pending=1. Later WB rd=8 → 0.
- Same-cycle issue rd=9 and WB rd=3 (busy) → o_pending unchanged, busy[9]=1, busy[3]=0. Spurious WB rd=12 (not busy) → no change.
- With FROST_SCOREBOARD_STATS_EN and CNT_W=4, hold a RAW stall for 20 cycles → o_stall_cycles=15 (saturated). Without the macro → 0.

Source files
------------

// File: rtl/int_reg_scoreboard_if.sv
// ID-stage operand/destination request, WB completion report and the stall reply
// exchanged between the decode pipeline (master) and the integer-register scoreboard (slave).
interface int_reg_scoreboard_if #(
  parameter int NUM_REGS = 32
);
  localparam int RW = $clog2(NUM_REGS);

  logic          i_id_valid;
  logic [RW-1:0] i_id_rs1;
  logic [RW-1:0] i_id_rs2;
  logic          i_id_rs1_used;
  logic          i_id_rs2_used;
  logic [RW-1:0] i_id_rd;
  logic          i_id_long_write;
  logic          i_id_mem_op;
  logic          i_wb_valid;
  logic [RW-1:0] i_wb_rd;
  logic          o_stall;

  modport master (
    output i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    output i_id_rd, i_id_long_write, i_id_mem_op, i_wb_valid, i_wb_rd,
    input  o_stall
  );

  modport slave (
    input  i_id_valid, i_id_rs1, i_id_rs2, i_id_rs1_used, i_id_rs2_used,
    input  i_id_rd, i_id_long_write, i_id_mem_op, i_wb_valid, i_wb_rd,
    output o_stall
  );
endinterface

// File: rtl/int_reg_scoreboard.sv
// Tracks integer destinations of in-flight long-latency writers and stalls ID on RAW/WAW/full.
// Optional stall-cycle statistics counter is built only when FROST_SCOREBOARD_STATS_EN is defined.
module int_reg_scoreboard #(
  parameter int NUM_REGS    = 32,
  parameter int MAX_PENDING = 4,
  parameter int CNT_W       = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_flush,
  input  logic                             i_hold,
  int_reg_scoreboard_if.slave              sb,
  output logic [$clog2(MAX_PENDING+1)-1:0] o_pending,
  output logic [CNT_W-1:0]                 o_stall_cycles
);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [NUM_REGS-1:0] mem_q, mem_d;
  logic [NUM_REGS-1:0] clr;
  logic [PW-1:0]       pending_q, pending_d;
  logic [PW-1:0]       n_clr;
  logic                raw1, raw2, waw, full, stall, issue;

  always_comb begin
    raw1  = sb.i_id_rs1_used && (sb.i_id_rs1 != '0) && busy_q[sb.i_id_rs1];
    raw2  = sb.i_id_rs2_used && (sb.i_id_rs2 != '0) && busy_q[sb.i_id_rs2];
    waw   = sb.i_id_long_write && (sb.i_id_rd != '0) && busy_q[sb.i_id_rd];
    full  = sb.i_id_long_write && (sb.i_id_rd != '0) && (pending_q == PW'(MAX_PENDING));
    stall = sb.i_id_valid && (raw1 || raw2 || waw || full);
    issue = sb.i_id_valid && sb.i_id_long_write && (sb.i_id_rd != '0) &&
            !stall && !i_hold && !i_flush;

    // Flush drops only core-side writers; memory-side ones still owe a WB.
    clr = '0;
    if (sb.i_wb_valid) clr[sb.i_wb_rd] = 1'b1;
    if (i_flush)       clr = clr | ~mem_q;
    clr = clr & busy_q;

    n_clr = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      n_clr = n_clr + PW'(clr[r]);
    end

    busy_d = busy_q & ~clr;
    mem_d  = mem_q & ~clr;
    if (issue) begin
      busy_d[sb.i_id_rd] = 1'b1;
      mem_d[sb.i_id_rd]  = sb.i_id_mem_op;
    end
    busy_d[0] = 1'b0;
    mem_d[0]  = 1'b0;

    pending_d = pending_q - n_clr + PW'(issue);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      busy_q    <= '0;
      mem_q     <= '0;
      pending_q <= '0;
    end else begin
      busy_q    <= busy_d;
      mem_q     <= mem_d;
      pending_q <= pending_d;
    end
  end

  assign sb.o_stall = stall;
  assign o_pending  = pending_q;

`ifdef FROST_SCOREBOARD_STATS_EN
  logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

  always_comb begin
    stall_cycles_d = stall_cycles_q;
    if (stall && (stall_cycles_q != '1)) stall_cycles_d = stall_cycles_q + CNT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) stall_cycles_q <= '0;
    else          stall_cycles_q <= stall_cycles_d;
  end

  assign o_stall_cycles = stall_cycles_q;
`else
  assign o_stall_cycles = '0;
`endif
endmodule

// File: tb/tb_int_reg_scoreboard.sv
// Directed plus randomized check of int_reg_scoreboard against a set-of-busy-registers model.
module tb_int_reg_scoreboard;
  localparam int STAT_W = 4;

  logic              i_clk = 1'b0;
  logic              i_rst_n;
  logic              i_flush;
  logic              i_hold;
  logic [2:0]        o_pending;
  logic [STAT_W-1:0] o_stall_cycles;

  int n_tests = 0;
  int n_fail  = 0;

  bit m_busy[32];
  bit m_mem[32];
  int m_stat;

  int_reg_scoreboard_if sb ();

  int_reg_scoreboard #(.NUM_REGS(32), .MAX_PENDING(4), .CNT_W(STAT_W)) dut (
    .i_clk          (i_clk),
    .i_rst_n        (i_rst_n),
    .i_flush        (i_flush),
    .i_hold         (i_hold),
    .sb             (sb),
    .o_pending      (o_pending),
    .o_stall_cycles (o_stall_cycles)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int r = 1; r < 32; r++) c += int'(m_busy[r]);
    return c;
  endfunction

  function automatic bit m_stall_f();
    bit r1 = sb.i_id_rs1_used && sb.i_id_rs1 != 0 && m_busy[sb.i_id_rs1];
    bit r2 = sb.i_id_rs2_used && sb.i_id_rs2 != 0 && m_busy[sb.i_id_rs2];
    bit w  = sb.i_id_long_write && sb.i_id_rd != 0 && m_busy[sb.i_id_rd];
    bit f  = sb.i_id_long_write && sb.i_id_rd != 0 && m_count() == 4;
    return sb.i_id_valid && (r1 || r2 || w || f);
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) begin
      m_busy[r] = 1'b0;
      m_mem[r]  = 1'b0;
    end
    m_stat = 0;
  endtask

  task automatic idle();
    sb.i_id_valid = 0; sb.i_id_rs1 = 0; sb.i_id_rs2 = 0;
    sb.i_id_rs1_used = 0; sb.i_id_rs2_used = 0; sb.i_id_rd = 0;
    sb.i_id_long_write = 0; sb.i_id_mem_op = 0;
    sb.i_wb_valid = 0; sb.i_wb_rd = 0;
    i_flush = 0; i_hold = 0;
  endtask

  task automatic id_long(input int rd, input bit mem_op);
    idle();
    sb.i_id_valid = 1; sb.i_id_long_write = 1;
    sb.i_id_rd = 5'(rd); sb.i_id_mem_op = mem_op;
  endtask

  task automatic id_read(input int rs);
    idle();
    sb.i_id_valid = 1; sb.i_id_rs1_used = 1; sb.i_id_rs1 = 5'(rs);
  endtask

  task automatic expect_now(input string tag, input int stall_e, input int pend_e);
    #1;
    check({tag, "_stall"}, int'(sb.o_stall), stall_e);
    check({tag, "_pend"}, int'(o_pending), pend_e);
  endtask

  // One clock: compare against the model, then advance the model with the sampled inputs.
  task automatic cyc();
    bit st;
    bit iss;
    #1;
    st = m_stall_f();
    check("stall", int'(sb.o_stall), int'(st));
    check("pending", int'(o_pending), m_count());
    check("stall_cycles", int'(o_stall_cycles), m_stat);
    @(posedge i_clk);
    iss = sb.i_id_valid && sb.i_id_long_write && sb.i_id_rd != 0 && !st && !i_hold && !i_flush;
    if (i_flush)
      for (int r = 1; r < 32; r++) if (!m_mem[r]) m_busy[r] = 1'b0;
    if (sb.i_wb_valid) begin
      m_busy[sb.i_wb_rd] = 1'b0;
      m_mem[sb.i_wb_rd]  = 1'b0;
    end
    if (iss) begin
      m_busy[sb.i_id_rd] = 1'b1;
      m_mem[sb.i_id_rd]  = sb.i_id_mem_op;
    end
`ifdef FROST_SCOREBOARD_STATS_EN
    if (st && m_stat < (1 << STAT_W) - 1) m_stat++;
`endif
    @(negedge i_clk);
  endtask

  initial begin
    int exp_stat;
    idle();
    m_reset();
    i_rst_n = 0;
    sb.i_id_valid = 1; sb.i_id_rs1_used = 1; sb.i_id_rs1 = 5;
    expect_now("reset", 0, 0);
    check("reset_stat", int'(o_stall_cycles), 0);
    idle();
    repeat (2) @(negedge i_clk);
    i_rst_n = 1;

    // Load to x5 followed by a dependent read.
    id_long(5, 1);             expect_now("t1_issue", 0, 0); cyc();
    id_read(5);                expect_now("t1_raw", 1, 1);   cyc(); cyc();
    sb.i_wb_valid = 1; sb.i_wb_rd = 5;
    expect_now("t1_wb_same", 1, 1); cyc();
    sb.i_wb_valid = 0;         expect_now("t1_release", 0, 0); cyc();

    // Writes to x0 are never tracked.
    id_long(0, 1);             expect_now("t2_x0_issue", 0, 0); cyc();
    id_read(0); sb.i_id_rs2_used = 1;
    expect_now("t2_x0_read", 0, 0); cyc();

    // Fill all four slots, then a fifth writer waits for a free slot.
    for (int i = 1; i <= 4; i++) begin
      id_long(i, 0); expect_now("t3_fill", 0, i - 1); cyc();
    end
    id_long(6, 0);             expect_now("t3_full", 1, 4);  cyc();
    sb.i_wb_valid = 1; sb.i_wb_rd = 2;
    expect_now("t3_full_wb", 1, 4); cyc();
    sb.i_wb_valid = 0;         expect_now("t3_after_wb", 0, 3); cyc();
    idle();                    expect_now("t3_pend4", 0, 4); cyc();
    i_flush = 1;               cyc();
    i_flush = 0;               expect_now("t3_flushed", 0, 0); cyc();

    // Flush keeps memory-side entries only.
    id_long(7, 0); cyc();
    id_long(8, 1); cyc();
    idle(); i_flush = 1;       expect_now("t4_pre", 0, 2);   cyc();
    idle();                    expect_now("t4_flush", 0, 1);
    id_read(7);                expect_now("t4_r7", 0, 1);
    id_read(8);                expect_now("t4_r8", 1, 1);
    idle(); sb.i_wb_valid = 1; sb.i_wb_rd = 8; cyc();
    idle();                    expect_now("t4_wb8", 0, 0);
    id_long(10, 0); i_flush = 1; cyc();
    idle();                    expect_now("t4_flush_issue", 0, 0);
    id_long(11, 1); cyc();
    idle(); i_flush = 1; sb.i_wb_valid = 1; sb.i_wb_rd = 11; cyc();
    idle();                    expect_now("t4_flush_wb", 0, 0);

    // Simultaneous issue and completion; spurious completion; held issue.
    id_long(3, 1); cyc();
    id_long(9, 0); sb.i_wb_valid = 1; sb.i_wb_rd = 3;
    expect_now("t5_swap", 0, 1); cyc();
    idle();                    expect_now("t5_pend", 0, 1);
    id_read(9);                expect_now("t5_r9", 1, 1);
    id_read(3);                expect_now("t5_r3", 0, 1);
    idle(); sb.i_wb_valid = 1; sb.i_wb_rd = 12; cyc();
    idle();                    expect_now("t5_spurious", 0, 1);
    sb.i_wb_valid = 1; sb.i_wb_rd = 9; cyc();
    id_long(13, 0); i_hold = 1; cyc();
    idle();                    expect_now("t5_hold", 0, 0);

    // Long RAW stall drives the statistics counter into saturation.
    id_long(14, 1); cyc();
    id_read(14);
    repeat (20) cyc();
`ifdef FROST_SCOREBOARD_STATS_EN
    exp_stat = (1 << STAT_W) - 1;
`else
    exp_stat = 0;
`endif
    check("t6_stat_sat", int'(o_stall_cycles), exp_stat);
    idle(); sb.i_wb_valid = 1; sb.i_wb_rd = 14; cyc();

    // Asynchronous reset in the middle of a cycle.
    id_long(15, 1); cyc();
    id_read(15);
    #2 i_rst_n = 0;
    m_reset();
    expect_now("t7_async", 0, 0);
    check("t7_stat", int'(o_stall_cycles), 0);
    idle();
    @(negedge i_clk);
    i_rst_n = 1;
    id_long(16, 0);            expect_now("t7_first", 0, 0); cyc();
    idle();                    expect_now("t7_after", 0, 1);
    sb.i_wb_valid = 1; sb.i_wb_rd = 16; cyc();

    // Randomized traffic on a small register window to provoke hazards.
    for (int n = 0; n < 600; n++) begin
      sb.i_id_valid      = ($urandom_range(99) < 85);
      sb.i_id_rs1        = 5'($urandom_range(9));
      sb.i_id_rs2        = 5'($urandom_range(9));
      sb.i_id_rs1_used   = ($urandom_range(99) < 70);
      sb.i_id_rs2_used   = ($urandom_range(99) < 70);
      sb.i_id_rd         = 5'($urandom_range(9));
      sb.i_id_long_write = ($urandom_range(99) < 40);
      sb.i_id_mem_op     = 1'($urandom_range(1));
      sb.i_wb_valid      = ($urandom_range(99) < 35);
      sb.i_wb_rd         = 5'($urandom_range(9));
      i_flush            = ($urandom_range(99) < 4);
      i_hold             = ($urandom_range(99) < 10);
      cyc();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
